// File: rtl/operand_entry_sequencer.sv
// Collects two 2*SW_WIDTH-bit operands from a switch bank, half by half, and
// offers the completed pair to the FPMAC with a valid/ready handshake.
module operand_entry_sequencer #(
  parameter int SW_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pushButtonValid,
  input  logic                  clearButtonValid,
  input  logic [SW_WIDTH-1:0]   switches,
  output logic [2*SW_WIDTH-1:0] opA,
  output logic [2*SW_WIDTH-1:0] opB,
  output logic                  opValid,
  input  logic                  opReady,
  output logic [2:0]            stage,
  output logic                  busy
);

  // state  | meaning
  // A_LO   | waiting for low half of operand A
  // A_HI   | waiting for high half of operand A
  // B_LO   | waiting for low half of operand B
  // B_HI   | waiting for high half of operand B
  // SEND   | pair offered to FPMAC, waiting for opReady
  typedef enum logic [2:0] {
    A_LO = 3'd0,
    A_HI = 3'd1,
    B_LO = 3'd2,
    B_HI = 3'd3,
    SEND = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [2*SW_WIDTH-1:0] op_a_q, op_a_d;
  logic [2*SW_WIDTH-1:0] op_b_q, op_b_d;
  logic                  op_valid_q, op_valid_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;

    // Clear beats everything, including a capture or handshake in the same cycle.
    if (clearButtonValid) begin
      state_d    = A_LO;
      op_a_d     = '0;
      op_b_d     = '0;
      op_valid_d = 1'b0;
    end else begin
      case (state_q)
        A_LO: if (pushButtonValid) begin
          op_a_d[SW_WIDTH-1:0] = switches;
          state_d              = A_HI;
        end
        A_HI: if (pushButtonValid) begin
          op_a_d[2*SW_WIDTH-1:SW_WIDTH] = switches;
          state_d                       = B_LO;
        end
        B_LO: if (pushButtonValid) begin
          op_b_d[SW_WIDTH-1:0] = switches;
          state_d              = B_HI;
        end
        B_HI: if (pushButtonValid) begin
          op_b_d[2*SW_WIDTH-1:SW_WIDTH] = switches;
          state_d                       = SEND;
          op_valid_d                    = 1'b1;
        end
        SEND: if (op_valid_q && opReady) begin
          state_d    = A_LO;
          op_valid_d = 1'b0;
        end
        default: begin
          state_d    = A_LO;
          op_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != A_LO) || op_valid_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= A_LO;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign opA     = op_a_q;
  assign opB     = op_b_q;
  assign opValid = op_valid_q;
  assign stage   = state_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_operand_entry_sequencer.sv
// Directed bench for operand_entry_sequencer: expected operand pairs are queued
// at stimulus time and a negedge monitor checks every accepted handshake.
module tb_operand_entry_sequencer;

  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic           pushButtonValid;
  logic           clearButtonValid;
  logic [W-1:0]   switches;
  logic [2*W-1:0] opA, opB;
  logic           opValid;
  logic           opReady;
  logic [2:0]     stage;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [4*W-1:0] exp_q[$];

  operand_entry_sequencer #(.SW_WIDTH(W)) dut (
    .clock            (clock),
    .reset            (reset),
    .pushButtonValid  (pushButtonValid),
    .clearButtonValid (clearButtonValid),
    .switches         (switches),
    .opA              (opA),
    .opB              (opB),
    .opValid          (opValid),
    .opReady          (opReady),
    .stage            (stage),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A handshake is real only when reset is not overriding the edge.
  always @(negedge clock) begin
    if (reset && opValid && opReady) begin
      xfers++;
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", {opA, opB}, 64'h0);
        if ({opA, opB} == 64'h0) begin
          errors++;
          $display("FAIL unexpected_transfer: got transfer expected none");
        end
      end else begin
        chk("xfer_pair", {opA, opB}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [W-1:0] sw);
    pushButtonValid = 1'b1;
    switches        = sw;
    tick();
    pushButtonValid = 1'b0;
  endtask

  task automatic entry(input logic [2*W-1:0] a, input logic [2*W-1:0] b);
    push(a[W-1:0]);
    push(a[2*W-1:W]);
    push(b[W-1:0]);
    push(b[2*W-1:W]);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_stage"}, 64'(stage), 64'd0);
    chk({name, "_valid"}, 64'(opValid), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b0; pushButtonValid = 1'b0; clearButtonValid = 1'b0;
    switches = '0; opReady = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk_idle("reset");
    chk("reset_ops", {opA, opB}, 64'h0);

    // Basic entry
    exp_q.push_back({32'h0000_3F80, 32'h0000_4000});
    push(16'h3F80);
    chk("a_hi_stage", 64'(stage), 64'd1);
    chk("a_lo_cap", 64'(opA), 64'h0000_3F80);
    chk("busy_mid", 64'(busy), 64'd1);
    push(16'h0000);
    push(16'h4000);
    chk("b_hi_stage", 64'(stage), 64'd3);
    chk("valid_early", 64'(opValid), 64'd0);
    push(16'h0000);
    chk("send_stage", 64'(stage), 64'd4);
    chk("send_valid", 64'(opValid), 64'd1);
    chk("send_busy", 64'(busy), 64'd1);
    opReady = 1'b1;
    tick();
    opReady = 1'b0;
    chk_idle("after_xfer");
    chk("keep_opA", 64'(opA), 64'h0000_3F80);

    // Backpressure with stray strobes during SEND
    exp_q.push_back({32'h1111_2222, 32'h3333_4444});
    entry(32'h1111_2222, 32'h3333_4444);
    for (int i = 0; i < 10; i++) begin
      pushButtonValid = 1'b1;
      switches = 16'hFFFF;
      tick();
      chk("bp_valid", 64'(opValid), 64'd1);
      chk("bp_ops", {opA, opB}, 64'h1111_2222_3333_4444);
    end
    pushButtonValid = 1'b0;
    opReady = 1'b1;
    tick();
    opReady = 1'b0;
    chk_idle("bp_done");

    // Clear mid-entry, then a fresh entry
    push(16'h1234);
    push(16'h5678);
    chk("partial_opA", 64'(opA), 64'h5678_1234);
    clearButtonValid = 1'b1;
    tick();
    clearButtonValid = 1'b0;
    chk_idle("clear");
    chk("clear_ops", {opA, opB}, 64'h0);
    exp_q.push_back({32'hBBBB_AAAA, 32'hDDDD_CCCC});
    entry(32'hBBBB_AAAA, 32'hDDDD_CCCC);
    chk("fresh_valid", 64'(opValid), 64'd1);
    opReady = 1'b1;
    tick();
    opReady = 1'b0;

    // Clear and push colliding in B_LO
    push(16'h0001);
    push(16'h0002);
    chk("coll_stage_pre", 64'(stage), 64'd2);
    clearButtonValid = 1'b1;
    pushButtonValid  = 1'b1;
    switches         = 16'h7777;
    tick();
    clearButtonValid = 1'b0;
    pushButtonValid  = 1'b0;
    chk_idle("collision");
    chk("coll_ops", {opA, opB}, 64'h0);
    tick();
    chk("coll_hold", 64'(stage), 64'd0);

    // Clear together with accepted handshake in SEND
    exp_q.push_back({32'h0BAD_F00D, 32'h1357_2468});
    entry(32'h0BAD_F00D, 32'h1357_2468);
    clearButtonValid = 1'b1;
    opReady          = 1'b1;
    tick();
    clearButtonValid = 1'b0;
    opReady          = 1'b0;
    chk_idle("clr_xfer");
    chk("clr_xfer_ops", {opA, opB}, 64'h0);

    // Reset in SEND with opReady high: no transfer
    entry(32'hCAFE_BABE, 32'hDEAD_BEEF);
    chk("rst_send_valid", 64'(opValid), 64'd1);
    reset   = 1'b0;
    opReady = 1'b1;
    tick();
    reset   = 1'b1;
    opReady = 1'b0;
    chk_idle("rst_send");
    chk("rst_send_ops", {opA, opB}, 64'h0);

    // Back-to-back with opReady tied high
    opReady = 1'b1;
    exp_q.push_back({32'h89AB_4567, 32'hF00D_0123});
    entry(32'h89AB_4567, 32'hF00D_0123);
    chk("b2b1_valid", 64'(opValid), 64'd1);
    tick();
    chk("b2b1_pulse", 64'(opValid), 64'd0);
    exp_q.push_back({32'h2222_1111, 32'h4444_3333});
    entry(32'h2222_1111, 32'h4444_3333);
    chk("b2b2_valid", 64'(opValid), 64'd1);
    tick();
    chk("b2b2_pulse", 64'(opValid), 64'd0);
    opReady = 1'b0;
    tick();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("xfer_count", 64'(xfers), 64'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_entry_sequencer.md
OPERAND_ENTRY_SEQUENCER -- requirements
Module: operand_entry_sequencer

Interface
REQ-001 Parameter SW_WIDTH, default 16, width of the switch bank and of each operand half; each operand is 2*SW_WIDTH bits.
REQ-002 clock  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled only on rising clock edge.
REQ-004 pushButtonValid  input  1  single-cycle strobe meaning "capture switches now", from the upstream button edge detector.
REQ-005 clearButtonValid  input  1  single-cycle strobe meaning "abort entry, discard operands".
REQ-006 switches  input  SW_WIDTH  operand half value presented by the user.
REQ-007 opA  output  2*SW_WIDTH  assembled operand A, registered.
REQ-008 opB  output  2*SW_WIDTH  assembled operand B, registered.
REQ-009 opValid  output  1  opA/opB pair is complete and offered to the FPMAC, registered.
REQ-010 opReady  input  1  FPMAC accepts the pair in any cycle where opValid and opReady are both 1.
REQ-011 stage  output  3  current FSM state code for LED display, registered.
REQ-012 busy  output  1  high when stage is not A_LO or opValid is high, registered.

Function
REQ-013 FSM states and stage codes: A_LO=0, A_HI=1, B_LO=2, B_HI=3, SEND=4; codes 5-7 unused, decode to A_LO on the next edge.
REQ-014 A_LO + pushButtonValid: opA[SW_WIDTH-1:0] <= switches, next state A_HI.
REQ-015 A_HI + pushButtonValid: opA[2*SW_WIDTH-1:SW_WIDTH] <= switches, next state B_LO.
REQ-016 B_LO + pushButtonValid: opB[SW_WIDTH-1:0] <= switches, next state B_HI.
REQ-017 B_HI + pushButtonValid: opB[2*SW_WIDTH-1:SW_WIDTH] <= switches, next state SEND, opValid <= 1 on the same edge.
REQ-018 Latency: opValid rises the cycle after the fourth strobe is sampled; capture is exactly one edge after the strobe.
REQ-019 No pushButtonValid: state and operands hold.
REQ-020 SEND: opA, opB, opValid hold stable until transfer; pushButtonValid ignored.
REQ-021 Transfer (opValid && opReady): next edge opValid <= 0, state A_LO; opA/opB keep their values until overwritten.
REQ-022 opReady is ignored while opValid is 0.
REQ-023 clearButtonValid in any state: next edge state A_LO, opValid <= 0, opA <= 0, opB <= 0.
REQ-024 clearButtonValid and pushButtonValid in the same cycle: clear wins, no capture.
REQ-025 clearButtonValid in SEND with opReady=1 in the same cycle: handshake counts as a completed transfer; clear still zeroes the operands.
REQ-026 Strobe held high for N cycles: treated as N strobes, one capture per cycle. The upstream block guarantees single-cycle pulses.
REQ-027 busy and stage are derived from registered state; no combinational path from any input to any output.

Reset
REQ-028 reset=0 at a rising edge: state A_LO, stage=0, opA=0, opB=0, opValid=0, busy=0; this overrides all other inputs.
REQ-029 reset asserted mid-entry or in SEND discards partial operands; no transfer occurs on that edge even if opReady=1.

Verification
REQ-030 Basic entry: after reset, strobes with switches 0x3F80, 0x0000, 0x4000, 0x0000, then opReady=1 -> opA=0x00003F80, opB=0x00004000, opValid high for exactly 1 cycle, then stage=0.
REQ-031 Backpressure: complete entry, hold opReady=0 for 10 cycles with extra strobes -> opValid, opA, opB stay constant; opReady=1 -> transfer, then stage=0.
REQ-032 Clear mid-entry: two strobes (0x1234, 0x5678), then clearButtonValid -> opA=0, stage=0; next four strobes build fresh operands.
REQ-033 Collision: clearButtonValid and pushButtonValid together in B_LO -> stage=0, opB unchanged from 0, no capture.
REQ-034 Reset in SEND with opReady=1 -> no transfer; all outputs zero on the next cycle.
REQ-035 Back-to-back: two full entries with opReady tied to 1 -> two single-cycle opValid pulses, each carrying its own correct operand pair.
